// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: request/grant for the address phase, rvalid/rdata
// for the response phase. Responses cannot be back-pressured.
interface fetch_stage_if;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one outstanding imem read, redirect with stale-response
// discard, and a one-entry skid register behind the IF/ID output register.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no request; waiting for the skid register to drain
// S_REQ  | imem_req asserted with fetch_pc as address, waiting for grant
// S_WAIT | granted, waiting for rvalid (dropped if discard is set)
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall_c,
   input  logic          redirect_c,
   input  logic [31:0]   redirect_pc_i,
   fetch_stage_if.master imem,
   output logic [31:0]   pc_o,
   output logic [31:0]   instruction_o,
   output logic          valid_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic [31:0] redir_pc_q, redir_pc_d;
   logic        redir_pend_q, redir_pend_d;
   logic        discard_q, discard_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_instr_q, skid_instr_d;

   logic [31:0] redir_tgt;
   logic        out_free;
   logic        resp_keep;

   assign redir_tgt = {redirect_pc_i[31:2], 2'b00};
   assign out_free  = !stall_c || !out_valid_q;
   assign resp_keep = (state_q == S_WAIT) && imem.rvalid && !discard_q;

   assign imem.req      = (state_q == S_REQ);
   assign imem.addr     = fetch_pc_q;
   assign valid_o       = out_valid_q;
   assign pc_o          = out_pc_q;
   assign instruction_o = out_instr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         fetch_pc_q   <= RESET_PC;
         req_pc_q     <= '0;
         redir_pc_q   <= '0;
         redir_pend_q <= 1'b0;
         discard_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         out_pc_q     <= '0;
         out_instr_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         req_pc_q     <= req_pc_d;
         redir_pc_q   <= redir_pc_d;
         redir_pend_q <= redir_pend_d;
         discard_q    <= discard_d;
         out_valid_q  <= out_valid_d;
         out_pc_q     <= out_pc_d;
         out_instr_q  <= out_instr_d;
         skid_valid_q <= skid_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      req_pc_d     = req_pc_q;
      redir_pc_d   = redir_pc_q;
      redir_pend_d = redir_pend_q;
      discard_d    = discard_q;
      out_valid_d  = out_valid_q;
      out_pc_d     = out_pc_q;
      out_instr_d  = out_instr_q;
      skid_valid_d = skid_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;

      case (state_q)
         S_IDLE: if (!skid_valid_q) state_d = S_REQ;
         S_REQ: begin
            if (imem.gnt) begin
               req_pc_d     = fetch_pc_q;
               fetch_pc_d   = redir_pend_q ? redir_pc_q : fetch_pc_q + 32'd4;
               redir_pend_d = 1'b0;
               state_d      = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem.rvalid) begin
               if (discard_q) begin
                  discard_d = 1'b0;
                  state_d   = S_REQ;
               end else if (out_free) begin
                  state_d = S_REQ;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Skid drains first; a fresh response parks in the skid only when the output is held.
      if (out_free) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_pc_d     = skid_pc_q;
            out_instr_d  = skid_instr_q;
            skid_valid_d = 1'b0;
            skid_pc_d    = '0;
            skid_instr_d = '0;
         end else if (resp_keep) begin
            out_valid_d = 1'b1;
            out_pc_d    = req_pc_q;
            out_instr_d = imem.rdata;
         end else begin
            out_valid_d = 1'b0;
            out_pc_d    = '0;
            out_instr_d = '0;
         end
      end else if (resp_keep) begin
         skid_valid_d = 1'b1;
         skid_pc_d    = req_pc_q;
         skid_instr_d = imem.rdata;
      end

      if (redirect_c) begin
         out_valid_d  = 1'b0;
         out_pc_d     = '0;
         out_instr_d  = '0;
         skid_valid_d = 1'b0;
         skid_pc_d    = '0;
         skid_instr_d = '0;
         fetch_pc_d   = redir_tgt;
         redir_pend_d = 1'b0;
         case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
               discard_d = 1'b1;
               // Ungranted request must keep its address; the target is applied at grant.
               if (!imem.gnt) begin
                  fetch_pc_d   = fetch_pc_q;
                  redir_pc_d   = redir_tgt;
                  redir_pend_d = 1'b1;
               end
            end
            S_WAIT: begin
               if (imem.rvalid) begin
                  discard_d = 1'b0;
                  state_d   = S_REQ;
               end else begin
                  discard_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
